cgra_add_unit: RTL and testbench
================================

// Module: cgra_add_unit
// PURPOSE
//  Parametrised, handshaked add/sub unit for the CGRA tile datapath, next generation of the tile's 1-cycle adder.
//  Adds SUB, carry-chained multi-word ADC, running accumulate, valid/ready flow control, flags and an op counter.
//  Sits between tile operand muxes and the result/route register; on_off gates it exactly as in the existing tile.
// PARAMETERS
//  WIDTH     16  operand/result width in bits (>=2)
//  CNT_WIDTH 16  width of completed-operation counter
// PORTS
//  clk        in   1          clock; all state on rising edge
//  reset      in   1          asynchronous, active-high reset
//  on_off     in   1          tile enable; 0 = unit held flushed
//  in_valid   in   1          operands/op valid
//  in_ready   out  1          unit can accept operands this cycle
//  op         in   2          cgra_pkg::add_op_e: ADD, SUB, ADC, ACC
//  a          in   WIDTH      operand A
//  b          in   WIDTH      operand B (ignored for ACC)
//  acc_clr    in   1          clear accumulator and chain carry
//  out_valid  out  1          result valid
//  out_ready  in   1          downstream accepts result
//  c          out  WIDTH      result
//  carry_out  out  1          unsigned carry (ADD/ADC/ACC) / not-borrow (SUB)
//  ovf        out  1          signed overflow of the operation
//  zero       out  1          c == 0
//  op_count   out  CNT_WIDTH  results consumed downstream, wraps mod 2^CNT_WIDTH
// BEHAVIOUR
//  Reset (async assert): c=0, carry_out=0, ovf=0, zero=0, out_valid=0, op_count=0; acc=0, chain_c=0.
//  Handshake: accept when in_valid && in_ready; in_ready = on_off && (!out_valid || out_ready).
//  Latency 1: accepted op -> registered c/flags, out_valid=1 next cycle; full throughput with out_ready=1.
//  Output stalls: out_valid && !out_ready holds c/flags/out_valid stable; no new accept.
//  Ops (width WIDTH+1 internally, carry = bit WIDTH):
//    ADD: a+b;  SUB: a+~b+1 (carry_out=1 means no borrow);  ADC: a+b+chain_c;  ACC: acc+a, acc<=result.
//  chain_c updates to carry_out on every accepted ADD/ADC/SUB; ACC leaves it unchanged.
//  ovf: operand sign bits equal (b inverted for SUB) and result sign differs.
//  acc_clr: next cycle acc=0, chain_c=0; if same cycle as accepted ACC/ADC, clear applies first (acc/carry read as 0).
//  op_count increments on out_valid && out_ready.
//  on_off=0: synchronous flush next edge; out_valid=0, acc=0, chain_c=0; pending result dropped; op_count kept.
//  Reset mid-operation: pending result discarded, no out_valid glitch after release.
// CONFIGURATION
//  CGRA_ADD_SAT_EN defined: ADD/ADC/ACC clamp to all-ones on carry; SUB clamps to 0 on borrow;
//    carry_out/ovf still report the unclamped event; acc stores clamped value.
//  Undefined: results wrap mod 2^WIDTH; no clamp logic instantiated.
// STRUCTURE
//  cgra_pkg: typedef enum logic [1:0] add_op_e {ADD=0,SUB=1,ADC=2,ACC=3}; localparam defaults.
//  Sub-module cgra_add_core: combinational (a, b, cin, invert_b) -> {carry, sum, ovf}, plus clamp under SAT_EN.
//  Top: handshake, acc/chain_c registers, output/flag registers, op counter.
// TESTING
//  ADD a=16'hFFFF b=16'h0001, out_ready=1 -> next cycle c=0, carry_out=1, zero=1, ovf=0, op_count=1.
//  ADC chain: ADD 16'hFFFF+1 then ADC 0+0 -> second c=16'h0001 (32-bit 0x0001_0000 correct).
//  SUB 16'h0003-16'h0005 -> c=16'hFFFE, carry_out=0; with SAT_EN c=0.
//  Backpressure: out_ready=0 for 3 cycles -> in_ready=0, c stable; release -> one result, op_count+1.
//  ACC: acc_clr, then ACC a=10,20,30 -> c=10,30,60; on_off=0 one cycle -> out_valid=0, next ACC a=5 -> c=5.
//  Async reset mid-stall -> all outputs 0 immediately, in_ready=1 after release with on_off=1.

Source files
------------

// File: rtl/cgra_pkg.sv
// Shared types and defaults for the CGRA tile add/sub unit.
// The optional clamp build is selected with CGRA_ADD_SAT_EN (see cgra_add_core).
package cgra_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ADC = 2'd2,
        ACC = 2'd3
    } add_op_e;

    localparam int unsigned WIDTH_DEF     = 16;
    localparam int unsigned CNT_WIDTH_DEF = 16;

    // Ops whose carry feeds the multi-word chain register
    function automatic logic updates_chain(input add_op_e op);
        logic res;
        case (op)
            ADD:     res = 1'b1;
            SUB:     res = 1'b1;
            ADC:     res = 1'b1;
            ACC:     res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cgra_add_core.sv
// Combinational WIDTH-bit adder with optional B inversion, carry and signed overflow.
// With CGRA_ADD_SAT_EN defined the sum is clamped on carry (add) or borrow (subtract).
module cgra_add_core
    import cgra_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             invert_b,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   full_s;
    logic [WIDTH-1:0] raw_sum_s;

    // Single WIDTH+1 adder; carry is the top bit, overflow from operand/result signs
    always_comb begin
        if (invert_b) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
        full_s    = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin};
        raw_sum_s = full_s[WIDTH-1:0];
        carry     = full_s[WIDTH];
        ovf       = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (raw_sum_s[WIDTH-1] != a[WIDTH-1]);
    end

`ifdef CGRA_ADD_SAT_EN
    // Subtract clamps to zero on borrow, additions clamp to all-ones on carry
    always_comb begin
        if (invert_b && !carry) begin
            sum = {WIDTH{1'b0}};
        end else if (!invert_b && carry) begin
            sum = {WIDTH{1'b1}};
        end else begin
            sum = raw_sum_s;
        end
    end
`else
    assign sum = raw_sum_s;
`endif

endmodule

// File: rtl/cgra_add_unit.sv
// Handshaked add/sub/adc/accumulate unit for the CGRA tile datapath, 1-cycle latency.
// Define CGRA_ADD_SAT_EN to build the saturating variant of cgra_add_core.
module cgra_add_unit
    import cgra_pkg::*;
#(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 on_off,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  add_op_e              op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 acc_clr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     c,
    output logic                 carry_out,
    output logic                 ovf,
    output logic                 zero,
    output logic [CNT_WIDTH-1:0] op_count
);

    logic [WIDTH-1:0]     acc_r;
    logic                 chain_c_r;
    logic [WIDTH-1:0]     c_r;
    logic                 carry_out_r;
    logic                 ovf_r;
    logic                 zero_r;
    logic                 out_valid_r;
    logic [CNT_WIDTH-1:0] op_count_r;

    logic                 in_ready_s;
    logic                 accept_s;
    logic                 consume_s;
    logic [WIDTH-1:0]     acc_eff_s;
    logic                 chain_eff_s;
    logic [WIDTH-1:0]     op_a_s;
    logic [WIDTH-1:0]     op_b_s;
    logic                 cin_s;
    logic                 invert_b_s;
    logic [WIDTH-1:0]     core_sum_s;
    logic                 core_carry_s;
    logic                 core_ovf_s;

    // Handshake: a stalled result blocks new operands
    always_comb begin
        in_ready_s = on_off && (!out_valid_r || out_ready);
        accept_s   = in_valid && in_ready_s;
        consume_s  = out_valid_r && out_ready;
    end

    // acc_clr takes effect before a same-cycle ACC/ADC reads acc or chain carry
    always_comb begin
        if (acc_clr) begin
            acc_eff_s   = {WIDTH{1'b0}};
            chain_eff_s = 1'b0;
        end else begin
            acc_eff_s   = acc_r;
            chain_eff_s = chain_c_r;
        end
    end

    // Map the opcode onto the core's operand/cin/invert controls
    always_comb begin
        op_a_s     = a;
        op_b_s     = b;
        cin_s      = 1'b0;
        invert_b_s = 1'b0;
        case (op)
            ADD: begin
                op_a_s = a;
                op_b_s = b;
            end
            SUB: begin
                cin_s      = 1'b1;
                invert_b_s = 1'b1;
            end
            ADC: begin
                cin_s = chain_eff_s;
            end
            ACC: begin
                op_a_s = acc_eff_s;
                op_b_s = a;
            end
            default: begin
                op_a_s = a;
                op_b_s = b;
            end
        endcase
    end

    cgra_add_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a        (op_a_s),
        .b        (op_b_s),
        .cin      (cin_s),
        .invert_b (invert_b_s),
        .sum      (core_sum_s),
        .carry    (core_carry_s),
        .ovf      (core_ovf_s)
    );

    // Result/flag registers, accumulator and chain carry; on_off low flushes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r       <= {WIDTH{1'b0}};
            chain_c_r   <= 1'b0;
            c_r         <= {WIDTH{1'b0}};
            carry_out_r <= 1'b0;
            ovf_r       <= 1'b0;
            zero_r      <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (!on_off) begin
            acc_r       <= {WIDTH{1'b0}};
            chain_c_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (accept_s) begin
                c_r         <= core_sum_s;
                carry_out_r <= core_carry_s;
                ovf_r       <= core_ovf_s;
                zero_r      <= (core_sum_s == {WIDTH{1'b0}});
                out_valid_r <= 1'b1;
            end else if (consume_s) begin
                out_valid_r <= 1'b0;
            end

            if (accept_s && (op == ACC)) begin
                acc_r <= core_sum_s;
            end else if (acc_clr) begin
                acc_r <= {WIDTH{1'b0}};
            end

            if (accept_s && updates_chain(op)) begin
                chain_c_r <= core_carry_s;
            end else if (acc_clr) begin
                chain_c_r <= 1'b0;
            end
        end
    end

    // Count results taken downstream; survives on_off flushes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_count_r <= {CNT_WIDTH{1'b0}};
        end else if (consume_s) begin
            op_count_r <= op_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign c         = c_r;
    assign carry_out = carry_out_r;
    assign ovf       = ovf_r;
    assign zero      = zero_r;
    assign op_count  = op_count_r;

endmodule

// File: tb/tb_cgra_add_unit.sv
// Directed self-checking bench for cgra_add_unit (WIDTH=16, CNT_WIDTH=16).
module tb_cgra_add_unit;
    import cgra_pkg::*;

    logic        clk;
    logic        reset;
    logic        on_off;
    logic        in_valid;
    logic        in_ready;
    add_op_e     op;
    logic [15:0] a;
    logic [15:0] b;
    logic        acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] c;
    logic        carry_out;
    logic        ovf;
    logic        zero;
    logic [15:0] op_count;

    int n_assert;
    int n_fail;

    cgra_add_unit #(.WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .on_off    (on_off),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .carry_out (carry_out),
        .ovf       (ovf),
        .zero      (zero),
        .op_count  (op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input add_op_e o, input logic [15:0] av, input logic [15:0] bv);
        in_valid = 1'b1;
        op       = o;
        a        = av;
        b        = bv;
    endtask

    initial begin
        logic [15:0] exp_wrap;
        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        on_off    = 1'b0;
        in_valid  = 1'b0;
        op        = ADD;
        a         = 16'h0000;
        b         = 16'h0000;
        acc_clr   = 1'b0;
        out_ready = 1'b1;
        #2;
        check("rst_c", {16'h0, c}, 32'h0);
        check("rst_flags", {29'h0, carry_out, ovf, zero}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_op_count", {16'h0, op_count}, 32'h0);
        step();
        reset  = 1'b0;
        on_off = 1'b1;
        step();
        check("idle_in_ready", {31'h0, in_ready}, 32'h1);

        // ADD FFFF+1
        drive(ADD, 16'hFFFF, 16'h0001);
        step();
        check("add_valid", {31'h0, out_valid}, 32'h1);
`ifdef CGRA_ADD_SAT_EN
        check("add_c", {16'h0, c}, 32'h0000_FFFF);
        check("add_flags", {29'h0, carry_out, ovf, zero}, 32'h4);
`else
        check("add_c", {16'h0, c}, 32'h0);
        check("add_flags", {29'h0, carry_out, ovf, zero}, 32'h5);
`endif
        // ADC 0+0 picks up the chain carry
        drive(ADC, 16'h0000, 16'h0000);
        step();
        check("adc_c", {16'h0, c}, 32'h0000_0001);
        check("adc_carry", {31'h0, carry_out}, 32'h0);
        check("adc_op_count", {16'h0, op_count}, 32'h1);

        // SUB 3-5 borrows
        drive(SUB, 16'h0003, 16'h0005);
        step();
`ifdef CGRA_ADD_SAT_EN
        check("sub_c", {16'h0, c}, 32'h0);
`else
        check("sub_c", {16'h0, c}, 32'h0000_FFFE);
`endif
        check("sub_carry_ovf", {30'h0, carry_out, ovf}, 32'h0);
        check("sub_op_count", {16'h0, op_count}, 32'h2);

        // Signed overflow both directions
        drive(ADD, 16'h7FFF, 16'h0001);
        step();
        check("ovf_add_c", {16'h0, c}, 32'h0000_8000);
        check("ovf_add_flags", {29'h0, carry_out, ovf, zero}, 32'h2);
        drive(SUB, 16'h8000, 16'h0001);
        step();
        check("ovf_sub_c", {16'h0, c}, 32'h0000_7FFF);
        check("ovf_sub_flags", {29'h0, carry_out, ovf, zero}, 32'h6);
        check("ovf_op_count", {16'h0, op_count}, 32'h4);

        // Backpressure: result held three cycles, then released
        drive(ADD, 16'h1234, 16'h1111);
        step();
        check("bp_c", {16'h0, c}, 32'h0000_2345);
        check("bp_op_count0", {16'h0, op_count}, 32'h5);
        drive(ADD, 16'h0001, 16'h0001);
        out_ready = 1'b0;
        #1;
        check("bp_in_ready", {31'h0, in_ready}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_hold_c", {16'h0, c}, 32'h0000_2345);
            check("bp_hold_valid", {30'h0, out_valid, in_ready}, 32'h2);
            check("bp_hold_count", {16'h0, op_count}, 32'h5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp_release_valid", {31'h0, out_valid}, 32'h0);
        check("bp_release_count", {16'h0, op_count}, 32'h6);

        // Accumulate 10, 20, 30 after a clear
        drive(ACC, 16'd10, 16'hBEEF);
        acc_clr = 1'b1;
        step();
        acc_clr = 1'b0;
        check("acc1", {16'h0, c}, 32'd10);
        drive(ACC, 16'd20, 16'h0000);
        step();
        check("acc2", {16'h0, c}, 32'd30);
        drive(ACC, 16'd30, 16'h0000);
        step();
        check("acc3", {16'h0, c}, 32'd60);
        check("acc_op_count", {16'h0, op_count}, 32'h8);
        in_valid = 1'b0;
        on_off   = 1'b0;
        step();
        check("flush_valid_ready", {30'h0, out_valid, in_ready}, 32'h0);
        check("flush_op_count", {16'h0, op_count}, 32'h9);
        on_off = 1'b1;
        drive(ACC, 16'd5, 16'h0000);
        step();
        check("acc_after_flush", {16'h0, c}, 32'd5);
        check("acc_after_flush_valid", {31'h0, out_valid}, 32'h1);

        // Flushed chain carry: ADC FFFF+0 gives no carry-in
        drive(ADC, 16'hFFFF, 16'h0000);
        step();
        exp_wrap = 16'hFFFF;
        check("adc_no_chain", {16'h0, c}, {16'h0, exp_wrap});
        check("adc_no_chain_carry", {31'h0, carry_out}, 32'h0);

        // Async reset in the middle of a stall
        drive(ADD, 16'h0100, 16'h0200);
        step();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        step();
        check("pre_rst_c", {16'h0, c}, 32'h0000_0300);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_c", {16'h0, c}, 32'h0);
        check("mid_rst_valid_flags", {28'h0, out_valid, carry_out, ovf, zero}, 32'h0);
        check("mid_rst_op_count", {16'h0, op_count}, 32'h0);
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        step();
        check("post_rst_valid", {31'h0, out_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
